// File: rtl/player_pkg.sv
// ============================================================================
// Module  : player_pkg
// Brief   : Shared types and USB keycode constants for player motion control.
// Revision: 1.0
// ============================================================================
`default_nettype none

package player_pkg;

    localparam int VEL_W = 10;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } motion_state_e;

    // USB HID usage IDs
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_RIGHT = 8'h4F;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_UP    = 8'h52;

    function automatic logic key_pressed(input logic [7:0] k0,
                                         input logic [7:0] k1,
                                         input logic [7:0] key);
        return (k0 == key) || (k1 == key);
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_tick_gen.sv
// ============================================================================
// Module  : frame_tick_gen
// Brief   : 2-FF synchroniser plus registered rising-edge detect that turns
//           the asynchronous frame clock into a one-cycle frame_tick pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_tick_gen (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_frame_clk,
    output logic o_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= i_frame_clk;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_tick  <= r_sync2 & ~r_prev;
        end
    end

    assign o_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/player_motion_ctrl.sv
// ============================================================================
// Module  : player_motion_ctrl
// Brief   : Keycodes to signed per-frame X/Y velocity with jump/gravity FSM.
//           Optional jump buffer enabled by macro PLAYER_JUMP_BUFFER_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module player_motion_ctrl
    import player_pkg::*;
#(
    parameter logic [7:0]       KEY_LEFT        = KC_A,
    parameter logic [7:0]       KEY_RIGHT       = KC_D,
    parameter logic [7:0]       KEY_JUMP        = KC_W,
    parameter logic [VEL_W-1:0] MAX_VEL_X       = 10'd2,
    parameter logic [VEL_W-1:0] JUMP_VEL        = 10'd8,
    parameter logic [VEL_W-1:0] GRAVITY         = 10'd1,
    parameter logic [VEL_W-1:0] MAX_FALL_VEL    = 10'd8,
    parameter int               JUMP_BUF_FRAMES = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_clk,
    input  logic [7:0]       keycode0,
    input  logic [7:0]       keycode1,
    input  logic             on_ground,
    input  logic             hit_ceiling,
    input  logic             revive,
    output logic             frame_tick,
    output logic [VEL_W-1:0] x_motion,
    output logic [VEL_W-1:0] y_motion,
    output logic             facing_left,
    output logic [1:0]       motion_state
);

    logic w_tick;

    frame_tick_gen u_frame_tick_gen (
        .i_clk       (Clk),
        .i_rst_n     (Reset_n),
        .i_frame_clk (frame_clk),
        .o_tick      (w_tick)
    );

    motion_state_e    r_state, w_state_nx;
    logic [VEL_W-1:0] r_x, w_x_nx;
    logic [VEL_W-1:0] r_y, w_y_nx;
    logic [VEL_W-1:0] w_y_inc;
    logic             r_face, w_face_nx;
    logic             r_armed, w_armed_nx;
    logic             w_left, w_right, w_jump, w_jump_edge;
    logic             w_buf_hit;

    assign w_left      = key_pressed(keycode0, keycode1, KEY_LEFT);
    assign w_right     = key_pressed(keycode0, keycode1, KEY_RIGHT);
    assign w_jump      = key_pressed(keycode0, keycode1, KEY_JUMP);
    assign w_jump_edge = w_jump & r_armed;
    assign w_y_inc     = r_y + GRAVITY;

`ifdef PLAYER_JUMP_BUFFER_EN
    localparam int c_BUF_W = $clog2(JUMP_BUF_FRAMES + 1);
    logic [c_BUF_W-1:0] r_buf, w_buf_nx;
    // A press on the landing tick itself also counts as buffered.
    assign w_buf_hit = (r_buf != '0) | w_jump_edge;
`else
    assign w_buf_hit = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_face_nx  = r_face;
        w_armed_nx = r_armed;
`ifdef PLAYER_JUMP_BUFFER_EN
        w_buf_nx   = r_buf;
`endif
        if (revive) begin
            w_state_nx = GROUNDED;
            w_x_nx     = '0;
            w_y_nx     = '0;
            w_armed_nx = 1'b1;
`ifdef PLAYER_JUMP_BUFFER_EN
            w_buf_nx   = '0;
`endif
        end else if (w_tick) begin
            if (w_left && !w_right) begin
                w_x_nx    = '0 - MAX_VEL_X;
                w_face_nx = 1'b1;
            end else if (w_right && !w_left) begin
                w_x_nx    = MAX_VEL_X;
                w_face_nx = 1'b0;
            end else begin
                w_x_nx    = '0;
            end

            if (w_jump_edge) begin
                w_armed_nx = 1'b0;
            end else if (!w_jump) begin
                w_armed_nx = 1'b1;
            end

`ifdef PLAYER_JUMP_BUFFER_EN
            if (w_jump_edge && r_state == FALLING) begin
                w_buf_nx = c_BUF_W'(JUMP_BUF_FRAMES);
            end else if (r_buf != '0) begin
                w_buf_nx = r_buf - 1'b1;
            end
`endif

            case (r_state)
                GROUNDED: begin
                    if (w_jump_edge) begin
                        w_state_nx = RISING;
                        w_y_nx     = '0 - JUMP_VEL;
                    end else if (!on_ground) begin
                        w_state_nx = FALLING;
                        w_y_nx     = GRAVITY;
                    end else begin
                        w_y_nx     = '0;
                    end
                end
                RISING: begin
                    if (hit_ceiling) begin
                        w_state_nx = FALLING;
                        w_y_nx     = '0;
                    end else begin
                        w_y_nx = w_y_inc;
                        if (!w_y_inc[VEL_W-1]) begin
                            w_state_nx = FALLING;
                        end
                    end
                end
                FALLING: begin
                    if (on_ground) begin
                        if (w_buf_hit) begin
                            w_state_nx = RISING;
                            w_y_nx     = '0 - JUMP_VEL;
`ifdef PLAYER_JUMP_BUFFER_EN
                            w_buf_nx   = '0;
`endif
                        end else begin
                            w_state_nx = GROUNDED;
                            w_y_nx     = '0;
                        end
                    end else if ($signed(w_y_inc) > $signed(MAX_FALL_VEL)) begin
                        w_y_nx = MAX_FALL_VEL;
                    end else begin
                        w_y_nx = w_y_inc;
                    end
                end
                default: begin
                    w_state_nx = GROUNDED;
                    w_y_nx     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= GROUNDED;
            r_x     <= '0;
            r_y     <= '0;
            r_face  <= 1'b0;
            r_armed <= 1'b1;
`ifdef PLAYER_JUMP_BUFFER_EN
            r_buf   <= '0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_face  <= w_face_nx;
            r_armed <= w_armed_nx;
`ifdef PLAYER_JUMP_BUFFER_EN
            r_buf   <= w_buf_nx;
`endif
        end
    end

    assign frame_tick   = w_tick;
    assign x_motion     = r_x;
    assign y_motion     = r_y;
    assign facing_left  = r_face;
    assign motion_state = r_state;

endmodule

`default_nettype wire

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Stage directly upstream of the per-player sprite/position block. Turns raw USB keycodes into signed per-frame X/Y motion using a jump/gravity state machine.
- The downstream block adds x_motion and y_motion to its position once per frame tick.
- One instance per player; keycode mapping is set by parameters (e.g. A/D/W for one player, arrow keys for the other).

Parameters:
- KEY_LEFT, 8'h04, keycode for move-left
- KEY_RIGHT, 8'h07, keycode for move-right
- KEY_JUMP, 8'h1A, keycode for jump
- MAX_VEL_X, 10'd2, horizontal speed in px/frame
- JUMP_VEL, 10'd8, initial upward speed in px/frame
- GRAVITY, 10'd1, per-frame velocity increment
- MAX_FALL_VEL, 10'd8, terminal downward speed in px/frame
- JUMP_BUF_FRAMES, 3, jump-buffer depth in frames (used only with the optional feature)

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous active-low reset
- frame_clk  in  1  VGA vsync-derived frame clock, asynchronous to Clk
- keycode0  in  8  USB keycode slot 0 (8'h00 = none)
- keycode1  in  8  USB keycode slot 1 (8'h00 = none)
- on_ground  in  1  collision stage: player is standing on a surface
- hit_ceiling  in  1  collision stage: player's head is blocked
- revive  in  1  synchronous respawn request, active high
- frame_tick  out  1  one-Clk pulse per frame_clk rising edge
- x_motion  out  10  signed two's-complement X velocity
- y_motion  out  10  signed two's-complement Y velocity; positive is down
- facing_left  out  1  last horizontal direction
- motion_state  out  2  GROUNDED=0, RISING=1, FALLING=2

Behaviour:
- Reset (Reset_n=0), asynchronous:
  - frame_tick=0, x_motion=0, y_motion=0, facing_left=0, motion_state=GROUNDED.
  - Synchronisers cleared; jump_armed=1.
- Frame tick:
  - frame_clk passes through a 2-FF synchroniser, then a registered rising-edge detect.
  - frame_tick asserts 3 Clk after the frame_clk edge and lasts exactly 1 Clk.
- Key decode (combinational): a key counts as pressed if either keycode slot matches it.
  - left only → x_next = -MAX_VEL_X
  - right only → x_next = +MAX_VEL_X
  - both or neither → x_next = 0
  - facing_left updates only when exactly one direction is pressed.
- Jump edge:
  - jump_edge = jump pressed AND jump_armed.
  - jump_armed clears when a jump is taken and sets again only after the jump key has been released at some frame tick. Holding jump gives exactly one jump.
- Update rule: all registered outputs update on the Clk edge where frame_tick=1. Otherwise they hold. Output latency is 1 Clk after frame_tick.
- FSM, evaluated on frame_tick:
  - GROUNDED:
    - jump_edge → RISING, y = -JUMP_VEL
    - else !on_ground → FALLING, y = +GRAVITY
    - else y = 0
  - RISING:
    - hit_ceiling → FALLING, y = 0
    - else y += GRAVITY; if the new y ≥ 0 (signed) → FALLING
  - FALLING:
    - on_ground → GROUNDED, y = 0
    - else y = min(y + GRAVITY, MAX_FALL_VEL)
- Arithmetic:
  - All velocity maths is 10-bit signed, compared with $signed.
  - Saturation at MAX_FALL_VEL means no overflow is possible.
- Simultaneous events:
  - on_ground and jump_edge in GROUNDED → jump wins.
  - hit_ceiling and on_ground in RISING → hit_ceiling wins (go to FALLING); on_ground is evaluated on the next tick.
- revive: synchronous, takes priority over frame_tick.
  - Next Clk: GROUNDED, x_motion=0, y_motion=0, jump_armed=1. facing_left is unchanged.
- Reset mid-jump: returns immediately to reset values. No residual velocity.

Optional Feature:
- Macro: PLAYER_JUMP_BUFFER_EN
- Defined:
  - A jump_edge taken while in FALLING loads a down-counter with JUMP_BUF_FRAMES. The counter decrements on each frame_tick.
  - On the tick that FALLING→GROUNDED with the counter nonzero, the block goes straight to RISING with y = -JUMP_VEL and the counter clears.
- Undefined:
  - A jump press while airborne is discarded. jump_armed still clears, so the key must be released before the next jump.

Decomposition:
- Package player_pkg holds:
  - motion_state_e enum (2-bit)
  - USB keycode constants KC_A, KC_D, KC_W, KC_LEFT, KC_RIGHT, KC_UP
  - VEL_W = 10
- Sub-module frame_tick_gen: 2-FF synchroniser plus edge detect producing frame_tick. It is shared with the sprite animation logic.

Test Plan:
- Reset then idle: Reset_n low for 5 Clk with on_ground=1 and no keys, then 10 frames → x_motion=0, y_motion=0, state GROUNDED, frame_tick once per frame exactly 3 Clk after each frame_clk edge.
- Horizontal keys:
  - keycode0=8'h04 → x_motion=10'h3FE (-2) and facing_left=1 after the next tick.
  - Add keycode1=8'h07 → x_motion=0 and facing_left stays 1.
- Jump arc: hold 8'h1A with on_ground=1, then drop on_ground → y_motion sequence -8,-7,…,-1, then 0 with state FALLING, then 1,2,…,8,8. Assert on_ground → y=0, GROUNDED. Held key causes no second jump.
- Ceiling: hit_ceiling=1 on the third RISING tick → y_motion=0, FALLING. hit_ceiling and on_ground together while RISING → FALLING.
- revive during FALLING at y=5 on the same cycle as frame_tick → next Clk GROUNDED, y=0, x=0.
- With PLAYER_JUMP_BUFFER_EN: press jump 2 frames before landing → the landing tick yields RISING with y=-8. Without the macro → GROUNDED with y=0.
